// File: rtl/burst_adaptor_pkg.sv
// Shared types and width helpers for the burst line adaptor.
// Line and beat widths are expected to be powers of two.
package burst_adaptor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        READ_DONE,
        WRITE,
        WRITE_DONE
    } state_t;

    function automatic int beat_idx_w(input int line_w, input int burst_w);
        return $clog2(line_w / burst_w);
    endfunction

    function automatic int offset_bits(input int line_w);
        return $clog2(line_w / 8);
    endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// Line buffer that can be filled one beat at a time or loaded as a whole
// line. It reads back either the full line or the beat selected by idx_i.
module line_beat_buffer
    import burst_adaptor_pkg::*;
#(
    parameter int LINE_W    = 256,
    parameter int BURST_W   = 64,
    localparam int BEATS    = LINE_W / BURST_W,
    localparam int IDX_W    = beat_idx_w(LINE_W, BURST_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [LINE_W-1:0]  line_i,
    input  logic               wr_i,
    input  logic [IDX_W-1:0]   idx_i,
    input  logic [BURST_W-1:0] burst_i,
    output logic [LINE_W-1:0]  line_o,
    output logic [BURST_W-1:0] burst_o
);

    // Beat 0 occupies the least significant bits of the line.
    logic [BEATS-1:0][BURST_W-1:0] slice_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            slice_q <= '0;
        else if (load_i)
            slice_q <= line_i;
        else if (wr_i)
            slice_q[idx_i] <= burst_i;
    end

    assign line_o  = slice_q;
    assign burst_o = slice_q[idx_i];

endmodule

// File: rtl/burst_line_adaptor.sv
// Splits one cache-line read or write into LINE_W/BURST_W memory bursts.
// An optional posted mode acknowledges writes on capture and drains them afterwards.
module burst_line_adaptor
    import burst_adaptor_pkg::*;
#(
    parameter int LINE_W       = 256,
    parameter int BURST_W      = 64,
    parameter int ADDR_W       = 32,
    parameter bit POSTED_WRITE = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int IDX_W = beat_idx_w(LINE_W, BURST_W);
    localparam int OFFS  = offset_bits(LINE_W);
    localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-OFFS){1'b1}}, {OFFS{1'b0}}};
    localparam logic [IDX_W-1:0]  LAST_BEAT = IDX_W'(BEATS - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]  addr_q;
    logic               post_ack_q, post_ack_d;
    logic               latch_addr, load_line, store_beat;
    logic [BURST_W-1:0] beat_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            addr_q     <= '0;
            post_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            post_ack_q <= post_ack_d;
            if (latch_addr)
                addr_q <= address_i & ADDR_MASK;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        post_ack_d = 1'b0;
        latch_addr = 1'b0;
        load_line  = 1'b0;
        store_beat = 1'b0;
        case (state_q)
            IDLE: begin
                if (read_i) begin
                    latch_addr = 1'b1;
                    beat_d     = '0;
                    state_d    = READ;
                end else if (write_i) begin
                    latch_addr = 1'b1;
                    load_line  = 1'b1;
                    beat_d     = '0;
                    post_ack_d = POSTED_WRITE;
                    state_d    = WRITE;
                end
            end
            READ: begin
                if (resp_i) begin
                    store_beat = 1'b1;
                    beat_d     = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT)
                        state_d = READ_DONE;
                end
            end
            WRITE: begin
                if (resp_i) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT)
                        state_d = POSTED_WRITE ? IDLE : WRITE_DONE;
                end
            end
            READ_DONE, WRITE_DONE: state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    line_beat_buffer #(
        .LINE_W  (LINE_W),
        .BURST_W (BURST_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_line),
        .line_i  (line_i),
        .wr_i    (store_beat),
        .idx_i   (beat_q),
        .burst_i (burst_i),
        .line_o  (line_o),
        .burst_o (beat_data)
    );

    // The memory side is driven purely from registered state.
    assign read_o    = (state_q == READ);
    assign write_o   = (state_q == WRITE);
    assign resp_o    = (state_q == READ_DONE) || (state_q == WRITE_DONE) || post_ack_q;
    assign burst_o   = write_o ? beat_data : '0;
    assign address_o = addr_q;

endmodule

// File: tb/tb_burst_line_adaptor.sv
// Directed bench for burst_line_adaptor: a default, a posted-write and a 512-bit-line instance.
module tb_burst_line_adaptor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // default instance (_a)
    logic [255:0] line_i_a, line_o_a;
    logic [31:0]  addr_i_a, addr_o_a;
    logic         rd_i_a, wr_i_a, resp_o_a, rd_o_a, wr_o_a, resp_i_a;
    logic [63:0]  burst_i_a, burst_o_a;
    // posted-write instance (_p)
    logic [255:0] line_i_p, line_o_p;
    logic [31:0]  addr_i_p, addr_o_p;
    logic         rd_i_p, wr_i_p, resp_o_p, rd_o_p, wr_o_p, resp_i_p;
    logic [63:0]  burst_i_p, burst_o_p;
    // 512-bit line instance (_w)
    logic [511:0] line_i_w, line_o_w;
    logic [31:0]  addr_i_w, addr_o_w;
    logic         rd_i_w, wr_i_w, resp_o_w, rd_o_w, wr_o_w, resp_i_w;
    logic [63:0]  burst_i_w, burst_o_w;

    burst_line_adaptor u_dut_a (
        .clk(clk), .rst(rst), .line_i(line_i_a), .line_o(line_o_a), .address_i(addr_i_a),
        .read_i(rd_i_a), .write_i(wr_i_a), .resp_o(resp_o_a), .burst_i(burst_i_a),
        .burst_o(burst_o_a), .address_o(addr_o_a), .read_o(rd_o_a), .write_o(wr_o_a),
        .resp_i(resp_i_a)
    );

    burst_line_adaptor #(.POSTED_WRITE(1'b1)) u_dut_p (
        .clk(clk), .rst(rst), .line_i(line_i_p), .line_o(line_o_p), .address_i(addr_i_p),
        .read_i(rd_i_p), .write_i(wr_i_p), .resp_o(resp_o_p), .burst_i(burst_i_p),
        .burst_o(burst_o_p), .address_o(addr_o_p), .read_o(rd_o_p), .write_o(wr_o_p),
        .resp_i(resp_i_p)
    );

    burst_line_adaptor #(.LINE_W(512), .BURST_W(64)) u_dut_w (
        .clk(clk), .rst(rst), .line_i(line_i_w), .line_o(line_o_w), .address_i(addr_i_w),
        .read_i(rd_i_w), .write_i(wr_i_w), .resp_o(resp_o_w), .burst_i(burst_i_w),
        .burst_o(burst_o_w), .address_o(addr_o_w), .read_o(rd_o_w), .write_o(wr_o_w),
        .resp_i(resp_i_w)
    );

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0]  rbeat [4];
    logic [255:0] wline;
    logic         rsp_pat [8];
    int           sel_pat [8];

    initial begin
        n_vec = 0;
        n_err = 0;
        rbeat = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                  64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        wline = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        // ack on cycles 2,5,6,8 of the burst; sel is the beat expected on burst_o
        rsp_pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        sel_pat = '{0, 0, 1, 1, 1, 2, 3, 3};

        {line_i_a, addr_i_a, rd_i_a, wr_i_a, burst_i_a, resp_i_a} = '0;
        {line_i_p, addr_i_p, rd_i_p, wr_i_p, burst_i_p, resp_i_p} = '0;
        {line_i_w, addr_i_w, rd_i_w, wr_i_w, burst_i_w, resp_i_w} = '0;
        rst = 1'b1;
        #2;
        chkb("rst_read_o", rd_o_a, 1'b0);
        chkb("rst_write_o", wr_o_a, 1'b0);
        chkb("rst_resp_o", resp_o_a, 1'b0);
        chkv("rst_burst_o", 512'(burst_o_a), '0);
        chkv("rst_address_o", 512'(addr_o_a), '0);
        chkv("rst_line_o", 512'(line_o_a), '0);
        chkb("rst_p_resp_o", resp_o_p, 1'b0);
        chkb("rst_w_write_o", wr_o_w, 1'b0);
        chkv("rst_w_burst_o", 512'(burst_o_w), '0);
        #10 rst = 1'b0;
        tick();

        // read 0x1234_5678, memory acknowledges every cycle
        addr_i_a = 32'h1234_5678; rd_i_a = 1'b1; resp_i_a = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            burst_i_a = rbeat[k-1];
            chkb("rd_read_o", rd_o_a, 1'b1);
            chkb("rd_resp_early", resp_o_a, 1'b0);
            chkv("rd_address_o", 512'(addr_o_a), 512'(32'h1234_5660));
        end
        tick();
        chkb("rd_resp_c5", resp_o_a, 1'b1);
        chkb("rd_read_o_c5", rd_o_a, 1'b0);
        chkv("rd_line_o", 512'(line_o_a), 512'({64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}));
        rd_i_a = 1'b0;
        tick();
        chkb("rd_resp_c6", resp_o_a, 1'b0);
        chkb("rd_no_reaccept", rd_o_a, 1'b0);
        chkv("rd_line_held", 512'(line_o_a), 512'({64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}));

        // non-posted write with memory stalls
        line_i_a = wline; addr_i_a = 32'h0000_0080; wr_i_a = 1'b1; resp_i_a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            resp_i_a = rsp_pat[k];
            chkb("wr_write_o", wr_o_a, 1'b1);
            chkv("wr_burst_o", 512'(burst_o_a), 512'(wline[sel_pat[k]*64 +: 64]));
            chkb("wr_resp_early", resp_o_a, 1'b0);
        end
        tick();
        chkb("wr_resp", resp_o_a, 1'b1);
        chkb("wr_write_o_done", wr_o_a, 1'b0);
        chkv("wr_burst_o_idle", 512'(burst_o_a), '0);
        chkv("wr_address_o", 512'(addr_o_a), 512'(32'h0000_0080));
        wr_i_a = 1'b0; resp_i_a = 1'b0;
        tick();
        chkb("wr_resp_after", resp_o_a, 1'b0);
        chkb("wr_no_reaccept", wr_o_a, 1'b0);

        // read and write raised together: the read wins
        addr_i_a = 32'h0000_0047; rd_i_a = 1'b1; wr_i_a = 1'b1; resp_i_a = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            burst_i_a = 64'(k);
            chkb("both_read_o", rd_o_a, 1'b1);
            chkb("both_write_o", wr_o_a, 1'b0);
            chkv("both_burst_o", 512'(burst_o_a), '0);
        end
        tick();
        chkb("both_resp", resp_o_a, 1'b1);
        chkb("both_write_o_end", wr_o_a, 1'b0);
        chkv("both_address_o", 512'(addr_o_a), 512'(32'h0000_0040));
        chkv("both_line_o", 512'(line_o_a), 512'({64'h4, 64'h3, 64'h2, 64'h1}));
        rd_i_a = 1'b0; wr_i_a = 1'b0;
        tick();
        chkb("both_idle_rd", rd_o_a, 1'b0);
        chkb("both_idle_wr", wr_o_a, 1'b0);

        // reset asserted during read beat 2
        addr_i_a = 32'h00AB_CDEF; rd_i_a = 1'b1; resp_i_a = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            burst_i_a = 64'h0A + 64'(k);
        end
        #1 rst = 1'b1; rd_i_a = 1'b0;
        #1;
        chkb("mid_rst_read_o", rd_o_a, 1'b0);
        chkb("mid_rst_resp_o", resp_o_a, 1'b0);
        chkb("mid_rst_write_o", wr_o_a, 1'b0);
        chkv("mid_rst_address_o", 512'(addr_o_a), '0);
        chkv("mid_rst_line_o", 512'(line_o_a), '0);
        chkv("mid_rst_burst_o", 512'(burst_o_a), '0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chkb("post_rst_idle", rd_o_a, 1'b0);
        addr_i_a = 32'h0000_0100; rd_i_a = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            burst_i_a = 64'(k) << 8;
            chkb("fresh_read_o", rd_o_a, 1'b1);
        end
        tick();
        chkb("fresh_resp", resp_o_a, 1'b1);
        chkv("fresh_line_o", 512'(line_o_a), 512'({64'h400, 64'h300, 64'h200, 64'h100}));
        chkv("fresh_address_o", 512'(addr_o_a), 512'(32'h0000_0100));
        rd_i_a = 1'b0; resp_i_a = 1'b0;

        // posted write followed by a held read
        line_i_p = wline; addr_i_p = 32'h0000_1000; wr_i_p = 1'b1; resp_i_p = 1'b1;
        tick();
        chkb("pw_resp_c1", resp_o_p, 1'b1);
        chkb("pw_write_o_c1", wr_o_p, 1'b1);
        chkv("pw_burst_c1", 512'(burst_o_p), 512'(64'hAAAA_AAAA_AAAA_AAAA));
        wr_i_p = 1'b0; rd_i_p = 1'b1; addr_i_p = 32'h0000_2000;
        for (int k = 2; k <= 4; k++) begin
            tick();
            chkb("pw_resp_drain", resp_o_p, 1'b0);
            chkb("pw_write_o", wr_o_p, 1'b1);
            chkb("pw_read_blocked", rd_o_p, 1'b0);
            chkv("pw_burst_o", 512'(burst_o_p), 512'(wline[(k-1)*64 +: 64]));
            chkv("pw_address_o", 512'(addr_o_p), 512'(32'h0000_1000));
        end
        tick();
        chkb("pw_c5_read_o", rd_o_p, 1'b0);
        chkb("pw_c5_write_o", wr_o_p, 1'b0);
        chkb("pw_c5_resp_o", resp_o_p, 1'b0);
        chkv("pw_c5_burst_o", 512'(burst_o_p), '0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            burst_i_p = 64'(k) << 16;
            chkb("pr_read_o", rd_o_p, 1'b1);
            chkb("pr_write_o", wr_o_p, 1'b0);
        end
        tick();
        chkb("pr_resp", resp_o_p, 1'b1);
        chkv("pr_address_o", 512'(addr_o_p), 512'(32'h0000_2000));
        chkv("pr_line_o", 512'(line_o_p), 512'({64'h4_0000, 64'h3_0000, 64'h2_0000, 64'h1_0000}));
        rd_i_p = 1'b0; resp_i_p = 1'b0;

        // 512-bit line: 8 beats, 64-byte alignment
        addr_i_w = 32'h0000_1FFF; rd_i_w = 1'b1; resp_i_w = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            burst_i_w = 64'hA0 + 64'(k - 1);
            chkb("wide_read_o", rd_o_w, 1'b1);
            chkb("wide_resp_early", resp_o_w, 1'b0);
            chkv("wide_address_o", 512'(addr_o_w), 512'(32'h0000_1FC0));
        end
        tick();
        chkb("wide_resp_c9", resp_o_w, 1'b1);
        chkb("wide_read_o_c9", rd_o_w, 1'b0);
        chkv("wide_line_o", line_o_w, {64'hA7, 64'hA6, 64'hA5, 64'hA4, 64'hA3, 64'hA2, 64'hA1, 64'hA0});
        rd_i_w = 1'b0; resp_i_w = 1'b0;
        tick();
        chkb("wide_resp_c10", resp_o_w, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
